baser_257b_stream_checker: RTL and testbench

//  Receive-side checker for 256b/257b transcoded BASE-R streams; successor of the fixed-width 257b block counter.

---
 rtl/baser_257b_pkg.sv | 59 +++++
 rtl/baser_257b_stream_checker_lane_extract.sv | 82 ++++++++
 rtl/baser_257b_stream_checker.sv | 200 ++++++++++++++++++++
 tb/tb_baser_257b_stream_checker.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/baser_257b_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : baser_257b_pkg
//  Purpose  : Shared constants, block-type tables and helpers for the
//             256b/257b transcoded BASE-R stream checker.
//  Revision : 1.0  initial release
// ============================================================================
package baser_257b_pkg;

    // Header bit values (bit 0 of the transcoded word)
    localparam logic HDR_DATA = 1'b1;
    localparam logic HDR_CTRL = 1'b0;

    // Field offsets inside a hdr=0 word
    localparam int FLAG_LSB = 1;
    localparam int FLAG_W   = 4;
    localparam int NIB_LSB  = 5;
    localparam int NIB_W    = 4;
    localparam int REM_LSB  = 9;
    localparam int TYPE_W   = 8;

    // Flags pattern that claims all four lanes are data (illegal with hdr=0)
    localparam logic [FLAG_W-1:0] FLAGS_ALL_DATA = 4'hF;

    // Legal 64b/66b control block types
    localparam int NUM_LEGAL_TYPES = 15;
    localparam logic [TYPE_W-1:0] LEGAL_TYPES [NUM_LEGAL_TYPES] = '{
        8'h1E, 8'h2D, 8'h33, 8'h4B, 8'h55, 8'h66, 8'h78, 8'h87,
        8'h99, 8'hAA, 8'hB4, 8'hCC, 8'hD2, 8'hE1, 8'hFF
    };

    typedef enum logic [0:0] {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } lock_state_t;

    function automatic logic is_legal_type(input logic [TYPE_W-1:0] t);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < NUM_LEGAL_TYPES; i++) begin
            if (LEGAL_TYPES[i] == t) ok = 1'b1;
        end
        return ok;
    endfunction

    // The compressed type field carries only the upper nibble of the type
    function automatic logic is_legal_nibble(input logic [NIB_W-1:0] n);
        logic ok;
        logic [TYPE_W-1:0] t;
        ok = 1'b0;
        for (int i = 0; i < NUM_LEGAL_TYPES; i++) begin
            t = LEGAL_TYPES[i];
            if (t[TYPE_W-1 -: NIB_W] == n) ok = 1'b1;
        end
        return ok;
    endfunction

endpackage
`default_nettype wire

// File: rtl/baser_257b_stream_checker_lane_extract.sv
`default_nettype none
// ============================================================================
//  Module   : baser_257b_lane_extract
//  Purpose  : Combinational unpacking of a 257b transcoded word into four
//             64b lanes with per-lane type and control markers.
//  Revision : 1.0  initial release
// ============================================================================
module baser_257b_lane_extract
    import baser_257b_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int LANES      = 4,
    parameter int TC_WIDTH   = LANES*DATA_WIDTH + 1
) (
    input  logic [TC_WIDTH-1:0]                 tx_coded,
    output logic [LANES-1:0][DATA_WIDTH-1:0]    lane_payload,
    output logic [LANES-1:0][TYPE_W-1:0]        lane_type,
    output logic [LANES-1:0]                    lane_ctrl,
    output logic [LANES-1:0]                    lane_first_ctrl,
    output logic [NIB_W-1:0]                    comp_nibble,
    output logic                                all_data_flags
);

    localparam int IDX_W    = $clog2(LANES) + 1;
    localparam int REM_W    = DATA_WIDTH - TYPE_W;
    localparam int SLOT_LSB = REM_LSB + REM_W;

    logic                         hdr;
    logic [FLAG_W-1:0]            flags;
    logic [IDX_W-1:0]             first_idx;
    logic [DATA_WIDTH-1:0]        first_word;
    logic [LANES-2:0][DATA_WIDTH-1:0] slot;

    assign hdr            = tx_coded[0];
    assign flags          = tx_coded[FLAG_LSB +: FLAG_W];
    assign comp_nibble    = tx_coded[NIB_LSB +: NIB_W];
    assign all_data_flags = (hdr == HDR_CTRL) && (flags == FLAGS_ALL_DATA);

    // First control lane rebuilt from the 56b remainder; its low type nibble is not transmitted
    assign first_word = {tx_coded[REM_LSB +: REM_W], comp_nibble, 4'h0};

    // Lowest-indexed control lane; LANES when there is none
    always_comb begin
        first_idx = IDX_W'(LANES);
        for (int k = LANES-1; k >= 0; k--) begin
            if (!flags[k]) first_idx = IDX_W'(k);
        end
    end

    // The three full 64b slots that follow the first-lane remainder
    for (genvar j = 0; j < LANES-1; j++) begin : g_slot
        assign slot[j] = tx_coded[SLOT_LSB + j*DATA_WIDTH +: DATA_WIDTH];
    end

    // Lanes before the first control lane occupy their own slot, later lanes shift down by one
    for (genvar k = 0; k < LANES; k++) begin : g_lane
        localparam logic [IDX_W-1:0] LANE_IDX = IDX_W'(k);
        logic [DATA_WIDTH-1:0] own_slot;
        logic [DATA_WIDTH-1:0] prev_slot;

        if (k < LANES-1) begin : g_own
            assign own_slot = slot[k];
        end else begin : g_no_own
            assign own_slot = '0;
        end

        if (k > 0) begin : g_prev
            assign prev_slot = slot[k-1];
        end else begin : g_no_prev
            assign prev_slot = '0;
        end

        assign lane_payload[k]    = (hdr == HDR_DATA)      ? tx_coded[k*DATA_WIDTH + 1 +: DATA_WIDTH] :
                                    (LANE_IDX < first_idx) ? own_slot :
                                    (LANE_IDX == first_idx) ? first_word : prev_slot;
        assign lane_type[k]       = lane_payload[k][TYPE_W-1:0];
        assign lane_ctrl[k]       = (hdr == HDR_CTRL) && !flags[k];
        assign lane_first_ctrl[k] = (hdr == HDR_CTRL) && (first_idx == LANE_IDX);
    end

endmodule
`default_nettype wire

// File: rtl/baser_257b_stream_checker.sv
`default_nettype none
// ============================================================================
//  Module   : baser_257b_stream_checker
//  Purpose  : Receive-side checker for 256b/257b transcoded BASE-R streams:
//             block classification, saturating statistics, block-lock FSM.
//  Options  : BASER_257B_CHK_PATTERN_EN adds a data-byte pattern checker
//             and the o_pattern_err_count output.
//  Revision : 1.0  initial release
// ============================================================================
module baser_257b_stream_checker
    import baser_257b_pkg::*;
#(
    parameter int         DATA_WIDTH        = 64,
    parameter int         LANES             = 4,
    parameter int         TC_WIDTH          = LANES*DATA_WIDTH + 1,
    parameter int         CNT_WIDTH         = 32,
    parameter int         LOCK_GOOD         = 64,
    parameter int         LOCK_BAD          = 16,
    parameter logic [7:0] DATA_CHAR_PATTERN = 8'hAA
) (
    input  logic                 clk,
    input  logic                 i_rst,
    input  logic                 i_valid,
    input  logic                 i_clr,
    input  logic [TC_WIDTH-1:0]  i_tx_coded,
    output logic [CNT_WIDTH-1:0] o_block_count,
    output logic [CNT_WIDTH-1:0] o_data_count,
    output logic [CNT_WIDTH-1:0] o_ctrl_count,
    output logic [CNT_WIDTH-1:0] o_inv_block_count,
    output logic                 o_lock,
    output logic                 o_inv_block
`ifdef BASER_257B_CHK_PATTERN_EN
    ,
    output logic [CNT_WIDTH-1:0] o_pattern_err_count
`endif
);

    localparam int GOOD_W = (LOCK_GOOD > 1) ? $clog2(LOCK_GOOD) : 1;
    localparam int BAD_W  = (LOCK_BAD  > 1) ? $clog2(LOCK_BAD)  : 1;
    localparam logic [GOOD_W-1:0]    GOOD_MAX = GOOD_W'(LOCK_GOOD - 1);
    localparam logic [BAD_W-1:0]     BAD_MAX  = BAD_W'(LOCK_BAD - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX  = '1;

    if (LANES != 4 || TC_WIDTH != LANES*DATA_WIDTH + 1) begin : g_bad_cfg
        $error("baser_257b_stream_checker: LANES must be 4 and TC_WIDTH = LANES*DATA_WIDTH+1");
    end

    logic                              hdr;
    logic [LANES-1:0][DATA_WIDTH-1:0]  lane_payload;
    logic [LANES-1:0][TYPE_W-1:0]      lane_type;
    logic [LANES-1:0]                  lane_ctrl;
    logic [LANES-1:0]                  lane_first_ctrl;
    logic [NIB_W-1:0]                  comp_nibble;
    logic                              all_data_flags;
    logic                              later_type_bad;
    logic                              block_invalid;

    lock_state_t        state, state_next;
    logic [GOOD_W-1:0]  good_run, good_next;
    logic [BAD_W-1:0]   bad_run, bad_next;

    assign hdr = i_tx_coded[0];

    baser_257b_lane_extract #(
        .DATA_WIDTH (DATA_WIDTH),
        .LANES      (LANES),
        .TC_WIDTH   (TC_WIDTH)
    ) u_lane_extract (
        .tx_coded        (i_tx_coded),
        .lane_payload    (lane_payload),
        .lane_type       (lane_type),
        .lane_ctrl       (lane_ctrl),
        .lane_first_ctrl (lane_first_ctrl),
        .comp_nibble     (comp_nibble),
        .all_data_flags  (all_data_flags)
    );

    // Block validity: bad flags, bad compressed nibble, or an illegal full type on a later ctrl lane
    always_comb begin
        later_type_bad = 1'b0;
        for (int k = 0; k < LANES; k++) begin
            if (lane_ctrl[k] && !lane_first_ctrl[k] && !is_legal_type(lane_type[k]))
                later_type_bad = 1'b1;
        end
        block_invalid = (hdr == HDR_CTRL) &&
                        (all_data_flags || !is_legal_nibble(comp_nibble) || later_type_bad);
    end

    // Saturating statistics; clear takes priority over a block in the same cycle
    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            o_block_count     <= '0;
            o_data_count      <= '0;
            o_ctrl_count      <= '0;
            o_inv_block_count <= '0;
        end else if (i_clr) begin
            o_block_count     <= '0;
            o_data_count      <= '0;
            o_ctrl_count      <= '0;
            o_inv_block_count <= '0;
        end else if (i_valid) begin
            if (o_block_count != CNT_MAX) o_block_count <= o_block_count + 1'b1;
            if (block_invalid) begin
                if (o_inv_block_count != CNT_MAX) o_inv_block_count <= o_inv_block_count + 1'b1;
            end else if (hdr == HDR_DATA) begin
                if (o_data_count != CNT_MAX) o_data_count <= o_data_count + 1'b1;
            end else begin
                if (o_ctrl_count != CNT_MAX) o_ctrl_count <= o_ctrl_count + 1'b1;
            end
        end
    end

    // One-cycle flag for an invalid qualified block (independent of clear)
    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) o_inv_block <= 1'b0;
        else       o_inv_block <= i_valid && block_invalid;
    end

`ifdef BASER_257B_CHK_PATTERN_EN
    logic pattern_mismatch;

    // Any data byte of a data lane differing from the expected fill character
    always_comb begin
        pattern_mismatch = 1'b0;
        for (int k = 0; k < LANES; k++) begin
            for (int b = 0; b < DATA_WIDTH/8; b++) begin
                if (!lane_ctrl[k] && lane_payload[k][8*b +: 8] != DATA_CHAR_PATTERN)
                    pattern_mismatch = 1'b1;
            end
        end
    end

    // One count per valid block that carries at least one wrong data byte
    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            o_pattern_err_count <= '0;
        end else if (i_clr) begin
            o_pattern_err_count <= '0;
        end else if (i_valid && !block_invalid && pattern_mismatch &&
                     o_pattern_err_count != CNT_MAX) begin
            o_pattern_err_count <= o_pattern_err_count + 1'b1;
        end
    end
`endif

    // Lock FSM state and run-length registers
    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            state    <= HUNT;
            good_run <= '0;
            bad_run  <= '0;
        end else begin
            state    <= state_next;
            good_run <= good_next;
            bad_run  <= bad_next;
        end
    end

    // Lock FSM next state; runs are zeroed on every state change, held when i_valid is low
    always_comb begin
        state_next = state;
        good_next  = good_run;
        bad_next   = bad_run;
        if (i_valid) begin
            case (state)
                HUNT: begin
                    if (block_invalid) begin
                        good_next = '0;
                    end else if (good_run == GOOD_MAX) begin
                        state_next = LOCKED;
                        good_next  = '0;
                        bad_next   = '0;
                    end else begin
                        good_next = good_run + 1'b1;
                    end
                end
                LOCKED: begin
                    if (!block_invalid) begin
                        bad_next = '0;
                    end else if (bad_run == BAD_MAX) begin
                        state_next = HUNT;
                        good_next  = '0;
                        bad_next   = '0;
                    end else begin
                        bad_next = bad_run + 1'b1;
                    end
                end
                default: begin
                    state_next = HUNT;
                    good_next  = '0;
                    bad_next   = '0;
                end
            endcase
        end
    end

    assign o_lock = (state == LOCKED);

endmodule
`default_nettype wire

// File: tb/tb_baser_257b_stream_checker.sv
`default_nettype none
// ============================================================================
//  Module   : tb_baser_257b_stream_checker
//  Purpose  : Self-checking bench for baser_257b_stream_checker; a 32-bit
//             counter instance and a 4-bit counter instance share stimulus.
//  Revision : 1.0  initial release
// ============================================================================
module tb_baser_257b_stream_checker;

    logic         clk = 1'b0;
    logic         i_rst, i_valid, i_clr;
    logic [256:0] i_tx_coded;

    logic [31:0] blk_cnt, data_cnt, ctrl_cnt, inv_cnt;
    logic        lock, inv_pulse;
    logic [3:0]  blk4, data4, ctrl4, inv4;
    logic        lock4, inv_pulse4;
`ifdef BASER_257B_CHK_PATTERN_EN
    logic [31:0] perr_cnt;
    logic [3:0]  perr4;
`endif

    always #5 clk = ~clk;

    baser_257b_stream_checker dut (
        .clk               (clk),
        .i_rst             (i_rst),
        .i_valid           (i_valid),
        .i_clr             (i_clr),
        .i_tx_coded        (i_tx_coded),
        .o_block_count     (blk_cnt),
        .o_data_count      (data_cnt),
        .o_ctrl_count      (ctrl_cnt),
        .o_inv_block_count (inv_cnt),
        .o_lock            (lock),
        .o_inv_block       (inv_pulse)
`ifdef BASER_257B_CHK_PATTERN_EN
        ,
        .o_pattern_err_count (perr_cnt)
`endif
    );

    baser_257b_stream_checker #(.CNT_WIDTH(4)) dut4 (
        .clk               (clk),
        .i_rst             (i_rst),
        .i_valid           (i_valid),
        .i_clr             (i_clr),
        .i_tx_coded        (i_tx_coded),
        .o_block_count     (blk4),
        .o_data_count      (data4),
        .o_ctrl_count      (ctrl4),
        .o_inv_block_count (inv4),
        .o_lock            (lock4),
        .o_inv_block       (inv_pulse4)
`ifdef BASER_257B_CHK_PATTERN_EN
        ,
        .o_pattern_err_count (perr4)
`endif
    );

    logic [7:0] LEGAL [15] = '{8'h1E, 8'h2D, 8'h33, 8'h4B, 8'h55, 8'h66, 8'h78, 8'h87,
                               8'h99, 8'hAA, 8'hB4, 8'hCC, 8'hD2, 8'hE1, 8'hFF};

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model: plain integer counts, 4-bit view saturates at 15
    int m_blk, m_data, m_ctrl, m_inv, m_perr;
    int s_blk, s_data, s_ctrl, s_inv, s_perr;
    bit m_lock, m_pulse;
    int m_good, m_bad;

    function automatic bit legal(input logic [7:0] t);
        for (int i = 0; i < 15; i++) if (LEGAL[i] == t) return 1'b1;
        return 1'b0;
    endfunction

    function automatic int sat4(input int x);
        return (x >= 15) ? 15 : x + 1;
    endfunction

    // Encoder: lanes[64k+63:64k] hold full lanes, ctrl lanes carry their type in the low byte
    function automatic logic [256:0] pack(input logic hdr, input logic [3:0] flags,
                                          input logic [3:0] nib, input logic [255:0] lanes);
        logic [256:0] b;
        int f;
        int pos;
        b = '0;
        b[0] = hdr;
        if (hdr) begin
            b[256:1] = lanes;
            return b;
        end
        b[4:1] = flags;
        b[8:5] = nib;
        f = 4;
        for (int k = 3; k >= 0; k--) if (!flags[k]) f = k;
        if (f == 4) begin
            b[256:9] = lanes[247:0];
            return b;
        end
        b[64:9] = lanes[64*f + 8 +: 56];
        pos = 65;
        for (int k = 0; k < 4; k++) begin
            if (k != f) begin
                b[pos +: 64] = lanes[64*k +: 64];
                pos += 64;
            end
        end
        return b;
    endfunction

    task automatic model_reset();
        m_blk = 0; m_data = 0; m_ctrl = 0; m_inv = 0; m_perr = 0;
        s_blk = 0; s_data = 0; s_ctrl = 0; s_inv = 0; s_perr = 0;
        m_lock = 0; m_pulse = 0; m_good = 0; m_bad = 0;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic compare_all();
        check("block",    64'(blk_cnt),    64'(m_blk));
        check("data",     64'(data_cnt),   64'(m_data));
        check("ctrl",     64'(ctrl_cnt),   64'(m_ctrl));
        check("inv",      64'(inv_cnt),    64'(m_inv));
        check("lock",     64'(lock),       64'(m_lock));
        check("inv_pls",  64'(inv_pulse),  64'(m_pulse));
        check("block4",   64'(blk4),       64'(s_blk));
        check("data4",    64'(data4),      64'(s_data));
        check("ctrl4",    64'(ctrl4),      64'(s_ctrl));
        check("inv4",     64'(inv4),       64'(s_inv));
        check("lock4",    64'(lock4),      64'(m_lock));
        check("inv_pls4", 64'(inv_pulse4), 64'(m_pulse));
`ifdef BASER_257B_CHK_PATTERN_EN
        check("perr",     64'(perr_cnt),   64'(m_perr));
        check("perr4",    64'(perr4),      64'(s_perr));
`endif
    endtask

    // Apply one cycle of stimulus, advance the model from the spec rules, compare
    task automatic apply(input bit v, input bit c, input logic [256:0] b,
                         input bit inv, input bit perr);
        i_valid = v; i_clr = c; i_tx_coded = b;
        @(posedge clk); #1;
        m_pulse = v && inv;
        if (c) begin
            m_blk = 0; m_data = 0; m_ctrl = 0; m_inv = 0; m_perr = 0;
            s_blk = 0; s_data = 0; s_ctrl = 0; s_inv = 0; s_perr = 0;
        end else if (v) begin
            m_blk++; s_blk = sat4(s_blk);
            if (inv)       begin m_inv++;  s_inv  = sat4(s_inv);  end
            else if (b[0]) begin m_data++; s_data = sat4(s_data); end
            else           begin m_ctrl++; s_ctrl = sat4(s_ctrl); end
            if (!inv && perr) begin m_perr++; s_perr = sat4(s_perr); end
        end
        if (v) begin
            if (!m_lock) begin
                if (inv) m_good = 0;
                else if (m_good + 1 == 64) begin m_lock = 1; m_good = 0; m_bad = 0; end
                else m_good++;
            end else begin
                if (!inv) m_bad = 0;
                else if (m_bad + 1 == 16) begin m_lock = 0; m_good = 0; m_bad = 0; end
                else m_bad++;
            end
        end
        compare_all();
        i_valid = 0; i_clr = 0;
    endtask

    // Random block built from lane descriptions; validity/pattern errors known by construction
    task automatic gen(output logic [256:0] b, output bit inv, output bit perr);
        int kind;
        logic [255:0] lanes;
        logic [3:0] flags, nib;
        logic [7:0] t;
        int f;
        int later[$];
        int datl[$];
        bit corrupt;
        kind = $urandom_range(0, 4);
        inv = 0; perr = 0;
        corrupt = ($urandom_range(0, 4) == 0);
        lanes = {32{8'hAA}};
        if (kind == 0) begin
            if (corrupt) lanes[8*$urandom_range(0, 31) +: 8] = 8'h00;
            b = pack(1'b1, 4'h0, 4'h0, lanes);
            perr = corrupt;
            return;
        end
        if (kind == 2) begin
            lanes = {$urandom(), $urandom(), $urandom(), $urandom(),
                     $urandom(), $urandom(), $urandom(), $urandom()};
            b = pack(1'b0, 4'hF, 4'($urandom_range(0, 15)), lanes);
            inv = 1;
            return;
        end
        do flags = 4'($urandom_range(0, 14)); while (kind == 4 && $countones(~flags) < 2);
        f = -1;
        for (int k = 0; k < 4; k++) begin
            if (!flags[k]) begin
                lanes[64*k +: 64] = {$urandom(), $urandom()};
                lanes[64*k +: 8]  = LEGAL[$urandom_range(0, 14)];
                if (f < 0) f = k; else later.push_back(k);
            end else begin
                datl.push_back(k);
            end
        end
        nib = lanes[64*f + 4 +: 4];
        if (kind == 3) begin nib = 4'h0; inv = 1; end
        if (kind == 4) begin
            do t = 8'($urandom_range(0, 255)); while (legal(t));
            lanes[64*later[$urandom_range(0, later.size()-1)] +: 8] = t;
            inv = 1;
        end
        if (corrupt && datl.size() > 0) begin
            lanes[64*datl[$urandom_range(0, datl.size()-1)] + 8*$urandom_range(0, 7) +: 8] = 8'h00;
            perr = !inv;
        end
        b = pack(1'b0, flags, nib, lanes);
    endtask

    initial begin
        logic [255:0] ln;
        logic [256:0] aa_blk, ctrl_ok, bad_blk, b;
        bit inv, perr;

        aa_blk  = pack(1'b1, 4'h0, 4'h0, {32{8'hAA}});
        ln      = {32{8'hAA}};
        ln[7:0] = 8'h1E;
        ctrl_ok = pack(1'b0, 4'hE, 4'h1, ln);
        bad_blk = pack(1'b0, 4'hF, 4'h0, {8{32'h1234_5678}});

        // Reset state
        i_rst = 1; i_valid = 0; i_clr = 0; i_tx_coded = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        compare_all();
        i_rst = 0;

        // 64 data blocks -> lock on the cycle after the 64th
        for (int i = 0; i < 64; i++) begin
            apply(1, 0, aa_blk, 0, 0);
            if (i == 62) check("lock_at_63", 64'(lock), 64'd0);
        end
        check("data_64",  64'(data_cnt), 64'd64);
        check("block_64", 64'(blk_cnt),  64'd64);
        check("inv_0",    64'(inv_cnt),  64'd0);
        check("lock_64",  64'(lock),     64'd1);
        check("sat4_blk", 64'(blk4),     64'd15);

        // Legal control block with compressed nibble 1
        apply(1, 0, ctrl_ok, 0, 0);
        check("ctrl_1",     64'(ctrl_cnt),  64'd1);
        check("no_inv_pls", 64'(inv_pulse), 64'd0);

        // 15 invalid then one valid keeps lock; 16 invalid drop it
        for (int i = 0; i < 15; i++) apply(1, 0, bad_blk, 1, 0);
        apply(1, 0, ctrl_ok, 0, 0);
        check("lock_kept", 64'(lock), 64'd1);
        for (int i = 0; i < 16; i++) begin
            apply(1, 0, bad_blk, 1, 0);
            if (i == 14) check("lock_at_15bad", 64'(lock), 64'd1);
        end
        check("lock_lost", 64'(lock),    64'd0);
        check("inv_31",    64'(inv_cnt), 64'd31);

        // All-ctrl block with an illegal type 0x12 in lane 2
        ln = {$urandom(), $urandom(), $urandom(), $urandom(),
              $urandom(), $urandom(), $urandom(), $urandom()};
        ln[7:0] = 8'h1E; ln[71:64] = 8'h2D; ln[135:128] = 8'h12; ln[199:192] = 8'h33;
        apply(1, 0, pack(1'b0, 4'h0, 4'h1, ln), 1, 0);
        check("inv_pls_hi", 64'(inv_pulse), 64'd1);
        apply(0, 0, aa_blk, 0, 0);
        check("inv_pls_lo", 64'(inv_pulse), 64'd0);

        // Clear together with a valid block: nothing counted
        apply(1, 1, aa_blk, 0, 0);
        check("clr_block",  64'(blk_cnt), 64'd0);
        check("clr_block4", 64'(blk4),    64'd0);

`ifdef BASER_257B_CHK_PATTERN_EN
        ln = {32{8'hAA}};
        ln[47:40] = 8'h00;
        apply(1, 0, pack(1'b1, 4'h0, 4'h0, ln), 0, 1);
        check("perr_1", 64'(perr_cnt), 64'd1);
`endif

        // Randomized mix of valid/idle/clear cycles
        for (int i = 0; i < 400; i++) begin
            gen(b, inv, perr);
            apply(($urandom_range(0, 9) < 8), ($urandom_range(0, 29) == 0), b, inv, perr);
        end

        // Asynchronous reset mid-stream
        for (int i = 0; i < 20; i++) apply(1, 0, aa_blk, 0, 0);
        #2;
        i_valid = 1; i_tx_coded = aa_blk;
        i_rst = 1;
        #1;
        model_reset();
        compare_all();
        @(posedge clk); #1;
        i_rst = 0; i_valid = 0;
        compare_all();
        for (int i = 0; i < 5; i++) apply(1, 0, aa_blk, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
